// File: rtl/mem_access_arbiter.sv
// Arbitrates fetch and load/store access to a single-port unified memory with registered pin drive.
// Define MEM_ARB_PROT_EN to reject data writes below DATA_BASE (d_err with d_ack, memory untouched).
module mem_access_arbiter #(
    parameter int AW        = 10,
    parameter int DW        = 16,
    parameter int DATA_BASE = 401
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_ack,
    output logic [DW-1:0] if_rdata,
    input  logic          d_req,
    input  logic          d_we,
    input  logic          d_ind,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_ack,
    output logic [DW-1:0] d_rdata,
    output logic          d_err,
    output logic [AW-1:0] mem_addr,
    output logic          mem_addr_mode,
    output logic [DW-1:0] mem_wdata,
    output logic          mem_wr,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy
);

`ifdef MEM_ARB_PROT_EN
    localparam bit PROT = 1'b1;
`else
    localparam bit PROT = 1'b0;
`endif
    localparam logic [AW-1:0] BASE = AW'(DATA_BASE);

    typedef enum logic [2:0] {IDLE, RD, WPTR, WSETUP, WSTROBE, DONE} state_t;

    state_t        state, state_nx;
    logic          last_fetch, last_fetch_nx;
    logic          gnt_fetch, gnt_fetch_nx;
    logic [AW-1:0] mem_addr_nx;
    logic [DW-1:0] mem_wdata_nx, if_rdata_nx, d_rdata_nx;
    logic          mem_wr_nx, mode_nx, reject;
    logic          if_ack_nx, d_ack_nx, d_err_nx, busy_nx;

    function automatic logic in_prog_region(input logic [AW-1:0] a);
        return PROT && (a < BASE);
    endfunction

    always_comb begin
        state_nx      = state;
        last_fetch_nx = last_fetch;
        gnt_fetch_nx  = gnt_fetch;
        mem_addr_nx   = mem_addr;
        mem_wdata_nx  = mem_wdata;
        if_rdata_nx   = if_rdata;
        d_rdata_nx    = d_rdata;
        mem_wr_nx     = 1'b0;
        mode_nx       = 1'b0;
        reject        = 1'b0;
        case (state)
            IDLE: begin
                // Round-robin on contention: the side not served last wins.
                if (if_req && (!d_req || !last_fetch)) begin
                    gnt_fetch_nx  = 1'b1;
                    last_fetch_nx = 1'b1;
                    mem_addr_nx   = if_addr;
                    state_nx      = RD;
                end else if (d_req) begin
                    gnt_fetch_nx  = 1'b0;
                    last_fetch_nx = 1'b0;
                    mem_addr_nx   = d_addr;
                    if (!d_we) begin
                        mode_nx  = d_ind;
                        state_nx = RD;
                    end else begin
                        mem_wdata_nx = d_wdata;
                        if (d_ind) begin
                            state_nx = WPTR;
                        end else if (in_prog_region(d_addr)) begin
                            reject   = 1'b1;
                            state_nx = DONE;
                        end else begin
                            state_nx = WSETUP;
                        end
                    end
                end
            end
            RD: begin
                if (gnt_fetch) if_rdata_nx = mem_rdata;
                else           d_rdata_nx  = mem_rdata;
                state_nx = DONE;
            end
            WPTR: begin
                // Pointer high bits are dropped: the effective address wraps.
                mem_addr_nx = mem_rdata[AW-1:0];
                if (in_prog_region(mem_rdata[AW-1:0])) begin
                    reject   = 1'b1;
                    state_nx = DONE;
                end else begin
                    state_nx = WSETUP;
                end
            end
            WSETUP: begin
                mem_wr_nx = 1'b1;
                state_nx  = WSTROBE;
            end
            WSTROBE: state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
        if_ack_nx = (state_nx == DONE) && gnt_fetch_nx;
        d_ack_nx  = (state_nx == DONE) && !gnt_fetch_nx;
        d_err_nx  = reject;
        busy_nx   = (state_nx != IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= IDLE;
            last_fetch    <= 1'b1;
            gnt_fetch     <= 1'b1;
            if_ack        <= 1'b0;
            d_ack         <= 1'b0;
            d_err         <= 1'b0;
            mem_wr        <= 1'b0;
            mem_addr_mode <= 1'b0;
            busy          <= 1'b0;
            mem_addr      <= '0;
            mem_wdata     <= '0;
            if_rdata      <= '0;
            d_rdata       <= '0;
        end else begin
            state         <= state_nx;
            last_fetch    <= last_fetch_nx;
            gnt_fetch     <= gnt_fetch_nx;
            if_ack        <= if_ack_nx;
            d_ack         <= d_ack_nx;
            d_err         <= d_err_nx;
            mem_wr        <= mem_wr_nx;
            mem_addr_mode <= mode_nx;
            busy          <= busy_nx;
            mem_addr      <= mem_addr_nx;
            mem_wdata     <= mem_wdata_nx;
            if_rdata      <= if_rdata_nx;
            d_rdata       <= d_rdata_nx;
        end
    end

endmodule

// File: tb/tb_mem_access_arbiter.sv
// Bench for mem_access_arbiter: behavioural memory on the pins plus a transaction-level reference model.
// Honours MEM_ARB_PROT_EN when it is defined for the whole compile.
module tb_mem_access_arbiter;
    localparam int AW = 10;
    localparam int DW = 16;
    localparam int DATA_BASE = 401;
`ifdef MEM_ARB_PROT_EN
    localparam bit PROT = 1'b1;
`else
    localparam bit PROT = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic          if_req, if_ack;
    logic [AW-1:0] if_addr;
    logic [DW-1:0] if_rdata;
    logic          d_req, d_we, d_ind, d_ack, d_err;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata, d_rdata;
    logic [AW-1:0] mem_addr;
    logic          mem_addr_mode, mem_wr, busy;
    logic [DW-1:0] mem_wdata, mem_rdata;

    always #5 clk = ~clk;

    mem_access_arbiter #(.AW(AW), .DW(DW), .DATA_BASE(DATA_BASE)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_ind(d_ind), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(d_ack), .d_rdata(d_rdata), .d_err(d_err),
        .mem_addr(mem_addr), .mem_addr_mode(mem_addr_mode), .mem_wdata(mem_wdata),
        .mem_wr(mem_wr), .mem_rdata(mem_rdata), .busy(busy)
    );

    // Physical memory attached to the pins; ref_mem is the model's view.
    logic [DW-1:0] mem     [0:1023];
    logic [DW-1:0] ref_mem [0:1023];
    int            wr_edges = 0;

    assign mem_rdata = mem_addr_mode ? mem[mem[mem_addr][AW-1:0]] : mem[mem_addr];

    always @(posedge mem_wr) begin
        mem[mem_addr] = mem_wdata;
        wr_edges++;
    end

    int n_cmp = 0;
    int n_bad = 0;
    bit last_f = 1'b1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic poke(input logic [AW-1:0] a, input logic [DW-1:0] v);
        mem[a]     = v;
        ref_mem[a] = v;
    endtask

    // One or two simultaneous requests; the model predicts grant order, timing and data.
    task automatic run_pair(input bit do_f, input logic [AW-1:0] fa, input bit do_d, input bit we,
                            input bit ind, input logic [AW-1:0] da, input logic [DW-1:0] wd);
        bit            f_first, exp_err, do_wr;
        logic [AW-1:0] eff;
        logic [DW-1:0] exp_f, exp_d;
        int            lf, ld, gf, gd, af, ad, last_n, w0;
        f_first = do_f && (!do_d || !last_f);
        eff     = ind ? ref_mem[da][AW-1:0] : da;
        exp_err = PROT && we && (int'(eff) < DATA_BASE);
        do_wr   = do_d && we && !exp_err;
        lf = 2;
        if (!we)         ld = 2;
        else if (exp_err) ld = ind ? 2 : 1;
        else             ld = ind ? 4 : 3;
        gf = 1; gd = 1;
        if (do_f && do_d) begin
            if (f_first) gd = 1 + lf + 1;
            else         gf = 1 + ld + 1;
        end
        af = gf + lf - 1;
        ad = gd + ld - 1;
        exp_f = '0; exp_d = '0;
        if (f_first) exp_f = ref_mem[fa];
        if (do_d) begin
            if (!we) exp_d = ref_mem[eff];
            else if (!exp_err) ref_mem[eff] = wd;
        end
        if (do_f && !f_first) exp_f = ref_mem[fa];
        if (do_f && do_d) last_f = !f_first;
        else              last_f = do_f;
        last_n = ((do_f && af > ad) || !do_d) ? af + 1 : ad + 1;

        w0 = wr_edges;
        if_req = do_f; if_addr = fa;
        d_req = do_d; d_we = we; d_ind = ind; d_addr = da; d_wdata = wd;
        for (int n = 1; n <= last_n; n++) begin
            @(posedge clk);
            @(negedge clk);
            chk("busy", 32'(busy), 32'((do_f && n >= gf && n <= af) || (do_d && n >= gd && n <= ad)));
            chk("if_ack", 32'(if_ack), 32'(do_f && n == af));
            chk("d_ack", 32'(d_ack), 32'(do_d && n == ad));
            chk("mem_wr", 32'(mem_wr), 32'(do_wr && n == ad - 1));
            chk("addr_mode", 32'(mem_addr_mode), 32'(do_d && !we && ind && n == gd));
            if (do_wr && n >= ad - 2 && n <= ad) begin
                chk("wr_addr", 32'(mem_addr), 32'(eff));
                chk("wr_data", 32'(mem_wdata), 32'(wd));
            end
            if (do_f && n == af) begin
                chk("if_rdata", 32'(if_rdata), 32'(exp_f));
                if_req = 1'b0;
            end
            if (do_d && n == ad) begin
                if (!we) chk("d_rdata", 32'(d_rdata), 32'(exp_d));
                chk("d_err", 32'(d_err), 32'(exp_err));
                d_req = 1'b0;
            end
        end
        chk("wr_edges", 32'(wr_edges - w0), 32'(do_wr));
        if (do_d && we) chk("mem_word", 32'(mem[eff]), 32'(ref_mem[eff]));
    endtask

    // Reset during a direct write: at_n=1 hits WSETUP (dropped), at_n=2 hits WSTROBE (committed).
    task automatic reset_mid(input int at_n);
        logic [AW-1:0] a;
        logic [DW-1:0] wd;
        int            w0;
        a  = AW'(DATA_BASE + $urandom_range(0, 600));
        wd = ~ref_mem[a];
        w0 = wr_edges;
        d_req = 1'b1; d_we = 1'b1; d_ind = 1'b0; d_addr = a; d_wdata = wd;
        for (int i = 0; i < at_n; i++) begin
            @(posedge clk);
            @(negedge clk);
        end
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("rst_mid_busy", 32'(busy), 32'(0));
        chk("rst_mid_ack", 32'(d_ack), 32'(0));
        chk("rst_mid_wr", 32'(mem_wr), 32'(0));
        d_req = 1'b0;
        rst_n = 1'b1;
        if (at_n == 2) ref_mem[a] = wd;
        last_f = 1'b1;
        chk("rst_mid_mem", 32'(mem[a]), 32'(ref_mem[a]));
        chk("rst_mid_edges", 32'(wr_edges - w0), 32'(at_n == 2));
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        int w0, sel;
        for (int i = 0; i < 1024; i++) begin
            mem[i]     = 16'($urandom);
            ref_mem[i] = mem[i];
        end
        rst_n = 1'b0;
        if_req = 1'b1; if_addr = 10'h003;
        d_req = 1'b1; d_we = 1'b1; d_ind = 1'b0; d_addr = 10'h200; d_wdata = 16'h5555;
        w0 = wr_edges;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_if_ack", 32'(if_ack), 32'(0));
        chk("rst_d_ack", 32'(d_ack), 32'(0));
        chk("rst_d_err", 32'(d_err), 32'(0));
        chk("rst_mem_wr", 32'(mem_wr), 32'(0));
        chk("rst_mode", 32'(mem_addr_mode), 32'(0));
        chk("rst_busy", 32'(busy), 32'(0));
        chk("rst_mem_addr", 32'(mem_addr), 32'(0));
        chk("rst_mem_wdata", 32'(mem_wdata), 32'(0));
        chk("rst_if_rdata", 32'(if_rdata), 32'(0));
        chk("rst_d_rdata", 32'(d_rdata), 32'(0));
        chk("rst_wr_edges", 32'(wr_edges - w0), 32'(0));
        rst_n = 1'b1;

        // Contention straight out of reset: data, fetch, data, fetch.
        run_pair(1'b1, 10'(($urandom_range(0, 1023))), 1'b1, 1'b0, 1'b0, 10'(($urandom_range(0, 1023))), '0);
        run_pair(1'b1, 10'(($urandom_range(0, 1023))), 1'b1, 1'b0, 1'b0, 10'(($urandom_range(0, 1023))), '0);

        poke(10'h005, 16'hA1B2);
        run_pair(1'b1, 10'h005, 1'b0, 1'b0, 1'b0, '0, '0);
        chk("fetch_word", 32'(if_rdata), 32'h0000A1B2);

        poke(10'h191, 16'h01A0);
        run_pair(1'b0, '0, 1'b1, 1'b1, 1'b1, 10'h191, 16'hBEEF);

        poke(10'h192, 16'h01A0);
        poke(10'h1A0, 16'h1234);
        run_pair(1'b0, '0, 1'b1, 1'b0, 1'b1, 10'h192, '0);
        chk("ind_read_word", 32'(d_rdata), 32'h00001234);

        run_pair(1'b0, '0, 1'b1, 1'b1, 1'b0, 10'h010, 16'hC0DE);
        run_pair(1'b0, '0, 1'b1, 1'b1, 1'b1, 10'h191, 16'h7777);
        run_pair(1'b1, 10'h3FF, 1'b0, 1'b0, 1'b0, '0, '0);

        reset_mid(1);
        reset_mid(2);

        for (int it = 0; it < 80; it++) begin
            sel = $urandom_range(1, 3);
            run_pair(sel[0], 10'($urandom_range(0, 1023)), sel[1], 1'($urandom_range(0, 1)),
                     1'($urandom_range(0, 1)), 10'($urandom_range(0, 1023)), 16'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
